// File: rtl/etod_pkg.sv
// ----------------------------------------------------------------------------
// etod_pkg
// Shared types and helpers for the etod initiator slice.
//   op_t     : command opcode as carried on cmd_op / select / rsp_op
//   state_t  : initiator transaction phases
//   expected : value the design should return for a given command
// Optional feature macro used by importers: ETOD_CHECK_EN
// ----------------------------------------------------------------------------
package etod_pkg;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_E2D   = 2'b01,
        OP_E2BUS = 2'b10,
        OP_BUS2D = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } state_t;

    // Widest data value the helper handles; callers cast to/from their width.
    localparam int EXP_W = 32;

    // An idle select produces no reply, so the design is expected to show 0.
    // Every other op echoes the command data back through dtoe or the bus.
    function automatic logic [EXP_W-1:0] expected(input op_t op,
                                                  input logic [EXP_W-1:0] data);
        return (op == OP_IDLE) ? '0 : data;
    endfunction

endpackage

// File: rtl/etod_checker.sv
// ----------------------------------------------------------------------------
// etod_checker
// Compares the captured design reply with the expected value and keeps a
// saturating mismatch counter. Only instantiated when ETOD_CHECK_EN is defined.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   capture    : high in the cycle whose ending edge captures the reply
//   op, data   : command being checked
//   captured   : reply value sampled at the end of CAPTURE
//   handshake  : response accepted this cycle
//   rsp_err    : registered mismatch flag, valid from entry to RESP
//   err_cnt    : saturating count of handshaken responses with rsp_err set
// ----------------------------------------------------------------------------
module etod_checker
    import etod_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture,
    input  op_t              op,
    input  logic [W-1:0]     data,
    input  logic [W-1:0]     captured,
    input  logic             handshake,
    output logic             rsp_err,
    output logic [CNT_W-1:0] err_cnt
);

    logic [W-1:0] exp_val;

    assign exp_val = W'(expected(op, EXP_W'(data)));

    // The error flag is refreshed only when a reply is captured so it stays
    // stable for the whole RESP phase; the counter saturates at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_err <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (capture) begin
                rsp_err <= (captured != exp_val);
            end
            if (handshake && rsp_err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/etod_initiator.sv
// ----------------------------------------------------------------------------
// etod_initiator
// Environment-side initiator: turns each accepted command into one select
// cycle toward the design, captures the design's reply on dtoe or the shared
// bus, and returns it through a valid/ready response handshake.
// Phases: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE; all outputs are registered.
// Optional feature: ETOD_CHECK_EN adds reply checking (rsp_err, err_cnt);
// without it both outputs are tied to 0.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   cmd_valid/ready/op/data : command input handshake
//   rsp_valid/ready/op/data/err : response output handshake
//   select, etod          : drive toward the design
//   dtoe                  : reply from the design
//   bus_o, bus_oe, bus_i  : our bus drive, enable, and the resolved bus
//   txn_cnt               : completed transactions (wraps)
//   err_cnt               : mismatching responses (saturates)
// ----------------------------------------------------------------------------
module etod_initiator
    import etod_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [W-1:0]     cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_op,
    output logic [W-1:0]     rsp_data,
    output logic             rsp_err,
    output logic [1:0]       select,
    output logic [W-1:0]     etod,
    input  logic [W-1:0]     dtoe,
    output logic [W-1:0]     bus_o,
    output logic             bus_oe,
    input  logic [W-1:0]     bus_i,
    output logic [CNT_W-1:0] txn_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic             cmd_ready_d;
    logic             rsp_valid_d;
    logic [1:0]       rsp_op_d;
    logic [W-1:0]     rsp_data_d;
    logic [1:0]       select_d;
    logic [W-1:0]     etod_d;
    logic [W-1:0]     bus_o_d;
    logic             bus_oe_d;
    logic [CNT_W-1:0] txn_cnt_d;
    logic [W-1:0]     captured;

    // A bus-directed op gets its reply on the shared bus; all others on dtoe.
    assign captured = (op_q == OP_E2BUS) ? bus_i : dtoe;

    // State and every output are registered together so the design sees
    // clean, edge-aligned select/etod/bus values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= OP_IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_op    <= 2'b00;
            rsp_data  <= '0;
            select    <= 2'b00;
            etod      <= '0;
            bus_o     <= '0;
            bus_oe    <= 1'b0;
            txn_cnt   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cmd_ready <= cmd_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_op    <= rsp_op_d;
            rsp_data  <= rsp_data_d;
            select    <= select_d;
            etod      <= etod_d;
            bus_o     <= bus_o_d;
            bus_oe    <= bus_oe_d;
            txn_cnt   <= txn_cnt_d;
        end
    end

    // Next-state and next-output decode. Values computed here appear on the
    // outputs in the phase being entered. bus_oe defaults low so it can only
    // ever be high during ISSUE, keeping it clear of the design's bus drive.
    // cmd_ready comes up one cycle after reset or a completed response, so
    // acceptance is always from a settled IDLE.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cmd_ready_d = cmd_ready;
        rsp_valid_d = rsp_valid;
        rsp_op_d    = rsp_op;
        rsp_data_d  = rsp_data;
        select_d    = select;
        etod_d      = etod;
        bus_o_d     = '0;
        bus_oe_d    = 1'b0;
        txn_cnt_d   = txn_cnt;

        case (state_q)
            IDLE: begin
                if (cmd_ready && cmd_valid) begin
                    state_d     = ISSUE;
                    op_d        = op_t'(cmd_op);
                    cmd_ready_d = 1'b0;
                    select_d    = cmd_op;
                    etod_d      = cmd_data;
                    if (op_t'(cmd_op) == OP_BUS2D) begin
                        bus_oe_d = 1'b1;
                        bus_o_d  = cmd_data;
                    end
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            ISSUE: begin
                state_d  = CAPTURE;
                select_d = 2'b00;
            end
            CAPTURE: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_op_d    = op_q;
                rsp_data_d  = captured;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    txn_cnt_d   = txn_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef ETOD_CHECK_EN
    logic capture;
    logic handshake;

    assign capture   = (state_q == CAPTURE);
    assign handshake = (state_q == RESP) && rsp_ready;

    // etod is still held during CAPTURE, so it doubles as the command data.
    etod_checker #(
        .W     (W),
        .CNT_W (CNT_W)
    ) u_checker (
        .clk       (clk),
        .rst       (rst),
        .capture   (capture),
        .op        (op_q),
        .data      (etod),
        .captured  (captured),
        .handshake (handshake),
        .rsp_err   (rsp_err),
        .err_cnt   (err_cnt)
    );
`else
    assign rsp_err = 1'b0;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_etod_initiator.sv
// ----------------------------------------------------------------------------
// tb_etod_initiator
// Self-checking bench for etod_initiator. A small behavioural design model
// answers select cycles (echo etod on dtoe, echo etod on the bus, or echo the
// bus on dtoe), optionally corrupting its reply. Expected responses come from
// the command rules: reply = 0 for op 00, otherwise cmd_data ^ corruption.
// Honours ETOD_CHECK_EN when computing expected rsp_err / err_cnt.
// ----------------------------------------------------------------------------
module tb_etod_initiator;

    localparam int W     = 4;
    localparam int CNT_W = 16;

`ifdef ETOD_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [W-1:0]     cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_op;
    logic [W-1:0]     rsp_data;
    logic             rsp_err;
    logic [1:0]       select;
    logic [W-1:0]     etod;
    logic [W-1:0]     dtoe;
    logic [W-1:0]     bus_o;
    logic             bus_oe;
    logic [W-1:0]     bus_i;
    logic [CNT_W-1:0] txn_cnt;
    logic [CNT_W-1:0] err_cnt;

    int checks = 0;
    int passes = 0;

    logic [CNT_W-1:0] exp_txn = '0;
    logic [CNT_W-1:0] exp_errs = '0;
    logic [W-1:0]     corrupt = '0;

    etod_initiator #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_op    (rsp_op),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .select    (select),
        .etod      (etod),
        .dtoe      (dtoe),
        .bus_o     (bus_o),
        .bus_oe    (bus_oe),
        .bus_i     (bus_i),
        .txn_cnt   (txn_cnt),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural design: samples select at the edge ending ISSUE and
    // replies during the following cycle.
    logic [1:0]   dsgn_sel = 2'b00;
    logic [W-1:0] dsgn_val = '0;
    logic         drv_en;

    always @(posedge clk) begin
        dsgn_sel <= select;
        dsgn_val <= (select == 2'b11) ? bus_i : etod;
    end

    assign drv_en = (dsgn_sel == 2'b10);
    assign dtoe   = (dsgn_sel == 2'b01 || dsgn_sel == 2'b11) ? (dsgn_val ^ corrupt) : '0;
    assign bus_i  = bus_oe ? bus_o : (drv_en ? (dsgn_val ^ corrupt) : '0);

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected_val);
        checks++;
        if (observed === expected_val) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h",
                     tag, observed, expected_val);
        end
    endtask

    // Bus must never be driven by both sides, and our drive is only legal
    // while presenting an op 11 select.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("bus_contention", 32'(bus_oe && drv_en), 32'd0);
            checkOutput("bus_oe_outside_op11", 32'(bus_oe && (select != 2'b11)), 32'd0);
        end
    end

    // One complete transaction; called at a negedge, returns at a negedge
    // in IDLE after the response handshake.
    task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] data,
                                 input logic [W-1:0] bad, input int hold);
        int           n;
        logic [W-1:0] exp_data;
        bit           exp_err;

        exp_data = (op == 2'b00) ? '0 : (data ^ bad);
        exp_err  = CHECK_EN && (op != 2'b00) && (bad != '0);

        corrupt   = bad;
        cmd_op    = op;
        cmd_data  = data;
        cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("cmd_accept_timeout", 32'(n < 20), 32'd1);

        @(negedge clk);
        cmd_valid = 1'b0;
        rsp_ready = 1'($urandom_range(0, 1));
        checkOutput("issue_select", 32'(select), 32'(op));
        checkOutput("issue_etod", 32'(etod), 32'(data));
        checkOutput("issue_bus_oe", 32'(bus_oe), 32'(op == 2'b11));
        if (op == 2'b11) checkOutput("issue_bus_o", 32'(bus_o), 32'(data));
        checkOutput("issue_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("issue_cmd_ready", 32'(cmd_ready), 32'd0);

        @(negedge clk);
        rsp_ready = 1'($urandom_range(0, 1));
        checkOutput("capture_select", 32'(select), 32'd0);
        checkOutput("capture_bus_oe", 32'(bus_oe), 32'd0);
        checkOutput("capture_etod", 32'(etod), 32'(data));
        checkOutput("capture_rsp_valid", 32'(rsp_valid), 32'd0);

        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("rsp_valid_latency3", 32'(rsp_valid), 32'd1);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rsp_op", 32'(rsp_op), 32'(op));
        checkOutput("rsp_data", 32'(rsp_data), 32'(exp_data));
        checkOutput("rsp_err", 32'(rsp_err), 32'(exp_err));

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("hold_rsp_data", 32'(rsp_data), 32'(exp_data));
            checkOutput("hold_rsp_op", 32'(rsp_op), 32'(op));
            checkOutput("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_txn = exp_txn + 1'b1;
        if (exp_err && exp_errs != '1) exp_errs = exp_errs + 1'b1;
        checkOutput("post_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("txn_cnt", 32'(txn_cnt), 32'(exp_txn));
        checkOutput("err_cnt", 32'(err_cnt), 32'(exp_errs));
    endtask

    initial begin
        int c;
        logic [CNT_W-1:0] base;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("reset_select", 32'(select), 32'd0);
        checkOutput("reset_etod", 32'(etod), 32'd0);
        checkOutput("reset_bus_o", 32'(bus_o), 32'd0);
        checkOutput("reset_bus_oe", 32'(bus_oe), 32'd0);
        checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_op", 32'(rsp_op), 32'd0);
        checkOutput("reset_rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("reset_txn_cnt", 32'(txn_cnt), 32'd0);
        checkOutput("reset_err_cnt", 32'(err_cnt), 32'd0);

        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        applyStimulus(2'b01, 4'hA, 4'h0, 0);
        applyStimulus(2'b10, 4'h5, 4'h0, 0);
        applyStimulus(2'b11, 4'h3, 4'h0, 0);
        applyStimulus(2'b00, 4'h9, 4'h0, 0);
        applyStimulus(2'b01, 4'h0, 4'hF, 0);
        applyStimulus(2'b10, 4'hC, 4'h0, 5);

        // Back-to-back with rsp_ready held high: three commands in 12 cycles
        corrupt   = '0;
        cmd_op    = 2'b01;
        cmd_data  = 4'h6;
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        base = exp_txn;
        checkOutput("b2b_start_ready", 32'(cmd_ready), 32'd1);
        c = 0;
        while (txn_cnt != base + 3'd3 && c < 40) begin
            @(negedge clk);
            c++;
            if (rsp_valid) checkOutput("b2b_rsp_data", 32'(rsp_data), 32'h6);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        exp_txn = exp_txn + 3'd3;
        checkOutput("b2b_cycles", 32'(c), 32'd12);
        checkOutput("b2b_txn_cnt", 32'(txn_cnt), 32'(exp_txn));

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            logic [1:0]   r_op;
            logic [W-1:0] r_data;
            logic [W-1:0] r_bad;
            r_op   = 2'($urandom_range(0, 3));
            r_data = W'($urandom);
            r_bad  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(1, 15)) : '0;
            applyStimulus(r_op, r_data, r_bad, int'($urandom_range(0, 3)));
        end

        // Reset while in CAPTURE discards the in-flight command
        corrupt   = '0;
        cmd_op    = 2'b01;
        cmd_data  = 4'h7;
        cmd_valid = 1'b1;
        c = 0;
        while (cmd_ready !== 1'b1 && c < 20) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        checkOutput("pre_reset_in_capture", 32'(rsp_valid || select != 2'b00), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_select", 32'(select), 32'd0);
        checkOutput("midrst_bus_oe", 32'(bus_oe), 32'd0);
        checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("midrst_txn_cnt", 32'(txn_cnt), 32'd0);
        checkOutput("midrst_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        exp_txn  = '0;
        exp_errs = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("midrst_no_response", 32'(rsp_valid), 32'd0);
        end
        rsp_ready = 1'b0;
        checkOutput("midrst_txn_after", 32'(txn_cnt), 32'd0);

        // Normal operation resumes after the mid-transaction reset
        applyStimulus(2'b11, 4'hB, 4'h0, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: observed running, expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
